// File: rtl/ram_arbiter_if.sv
// Bundle of the two requester ports and the single-port RAM bus seen by
// the arbiter. The arbiter takes the slave view; the requesters and the
// RAM model together take the master view.
interface ram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              ramCs;
    logic              ramWe;
    logic              ramRe;
    logic [ADDR_W-1:0] ramAddr;
    logic [DATA_W-1:0] ramDataOut;
    logic [DATA_W-1:0] ramDataIn;
    logic              busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ramDataIn,
        output ack0, ack1, rvalid0, rvalid1, rdata0, rdata1,
               ramCs, ramWe, ramRe, ramAddr, ramDataOut, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ramDataIn,
        input  ack0, ack1, rvalid0, rvalid1, rdata0, rdata1,
               ramCs, ramWe, ramRe, ramAddr, ramDataOut, busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous
// RAM. One command in flight at a time: IDLE -> ISSUE (-> CAPTURE for
// reads) -> IDLE. Every output comes straight from a flop.
module ram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          rstN,
    ram_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

    logic [1:0]        state_q,      state_d;
    logic              last_grant_q, last_grant_d;
    logic              gnt_q,        gnt_d;
    logic              lat_we_q,     lat_we_d;
    logic              ack0_q,       ack0_d;
    logic              ack1_q,       ack1_d;
    logic              rvalid0_q,    rvalid0_d;
    logic              rvalid1_q,    rvalid1_d;
    logic [DATA_W-1:0] rdata0_q,     rdata0_d;
    logic [DATA_W-1:0] rdata1_q,     rdata1_d;
    logic              ram_cs_q,     ram_cs_d;
    logic              ram_we_q,     ram_we_d;
    logic              ram_re_q,     ram_re_d;
    logic [ADDR_W-1:0] ram_addr_q,   ram_addr_d;
    logic [DATA_W-1:0] ram_dout_q,   ram_dout_d;
    logic              busy_q,       busy_d;

    // Winner of the current arbitration round and its command fields
    logic              pick;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Round-robin pick: a lone requester wins; on a tie the one not served last wins
    always_comb begin
        pick      = bus.req1 && (!bus.req0 || !last_grant_q);
        sel_we    = pick ? bus.we1    : bus.we0;
        sel_addr  = pick ? bus.addr1  : bus.addr0;
        sel_wdata = pick ? bus.wdata1 : bus.wdata0;
    end

    // Next-state and next-output logic; RAM strobes and acks are computed one
    // cycle early so that they appear registered during the ISSUE cycle
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        lat_we_d     = lat_we_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        ram_cs_d     = 1'b0;
        ram_we_d     = 1'b0;
        ram_re_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_dout_d   = ram_dout_q;

        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d      = ISSUE;
                    last_grant_d = pick;
                    gnt_d        = pick;
                    lat_we_d     = sel_we;
                    ack0_d       = !pick;
                    ack1_d       = pick;
                    ram_cs_d     = 1'b1;
                    ram_we_d     = sel_we;
                    ram_re_d     = !sel_we;
                    ram_addr_d   = sel_addr;
                    ram_dout_d   = sel_we ? sel_wdata : '0;
                end
            end
            ISSUE: begin
                // Writes are done once the RAM has seen the strobe; reads
                // need one more cycle for the RAM to present its data
                state_d = lat_we_q ? IDLE : CAPTURE;
            end
            CAPTURE: begin
                state_d = IDLE;
                if (gnt_q) begin
                    rdata1_d  = bus.ramDataIn;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = bus.ramDataIn;
                    rvalid0_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any command in flight
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            lat_we_q     <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            ram_cs_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_re_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_dout_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            lat_we_q     <= lat_we_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            ram_cs_q     <= ram_cs_d;
            ram_we_q     <= ram_we_d;
            ram_re_q     <= ram_re_d;
            ram_addr_q   <= ram_addr_d;
            ram_dout_q   <= ram_dout_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.ack0       = ack0_q;
    assign bus.ack1       = ack1_q;
    assign bus.rvalid0    = rvalid0_q;
    assign bus.rvalid1    = rvalid1_q;
    assign bus.rdata0     = rdata0_q;
    assign bus.rdata1     = rdata1_q;
    assign bus.ramCs      = ram_cs_q;
    assign bus.ramWe      = ram_we_q;
    assign bus.ramRe      = ram_re_q;
    assign bus.ramAddr    = ram_addr_q;
    assign bus.ramDataOut = ram_dout_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small synchronous RAM model.
module tb_ram_arbiter;
    logic clk;
    logic rstN;
    int   n_cmp;
    int   n_err;

    ram_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

    ram_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: write on strobe, read data valid the cycle after the strobe
    logic [7:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.ramCs && bus.ramWe) mem[bus.ramAddr[7:0]] <= bus.ramDataOut;
        if (bus.ramCs && bus.ramRe) bus.ramDataIn <= mem[bus.ramAddr[7:0]];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ack0"}, bus.ack0, 0);
        chk({tag, " ack1"}, bus.ack1, 0);
        chk({tag, " rvalid0"}, bus.rvalid0, 0);
        chk({tag, " rvalid1"}, bus.rvalid1, 0);
        chk({tag, " ramCs"}, bus.ramCs, 0);
        chk({tag, " ramWe"}, bus.ramWe, 0);
        chk({tag, " ramRe"}, bus.ramRe, 0);
        chk({tag, " ramAddr"}, bus.ramAddr, 0);
        chk({tag, " ramDataOut"}, bus.ramDataOut, 0);
        chk({tag, " rdata0"}, bus.rdata0, 0);
        chk({tag, " rdata1"}, bus.rdata1, 0);
        chk({tag, " busy"}, bus.busy, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rstN = 1'b0;
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        tick();
        tick();
        chk_all_zero("reset");
        rstN = 1'b1;
        tick();

        // Write from requester 0
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 16'h0FAA; bus.wdata0 = 8'hEA;
        tick();
        chk("wr0 ack0", bus.ack0, 1);
        chk("wr0 ack1", bus.ack1, 0);
        chk("wr0 ramCs", bus.ramCs, 1);
        chk("wr0 ramWe", bus.ramWe, 1);
        chk("wr0 ramRe", bus.ramRe, 0);
        chk("wr0 ramAddr", bus.ramAddr, 32'h0FAA);
        chk("wr0 ramDataOut", bus.ramDataOut, 32'hEA);
        chk("wr0 busy", bus.busy, 1);
        bus.req0 = 0;
        tick();
        chk("wr0 done ack0", bus.ack0, 0);
        chk("wr0 done ramCs", bus.ramCs, 0);
        chk("wr0 done busy", bus.busy, 0);

        // Read back by requester 0
        bus.req0 = 1; bus.we0 = 0;
        tick();
        chk("rd0 ack0", bus.ack0, 1);
        chk("rd0 ramRe", bus.ramRe, 1);
        chk("rd0 ramWe", bus.ramWe, 0);
        chk("rd0 ramDataOut", bus.ramDataOut, 0);
        chk("rd0 ramAddr", bus.ramAddr, 32'h0FAA);
        bus.req0 = 0;
        tick();
        chk("rd0 cap ack0", bus.ack0, 0);
        chk("rd0 cap ramCs", bus.ramCs, 0);
        chk("rd0 cap rvalid0", bus.rvalid0, 0);
        chk("rd0 cap busy", bus.busy, 1);
        tick();
        chk("rd0 rvalid0", bus.rvalid0, 1);
        chk("rd0 rdata0", bus.rdata0, 32'hEA);
        chk("rd0 rdata1", bus.rdata1, 0);
        chk("rd0 busy", bus.busy, 0);
        tick();
        chk("rd0 rvalid0 pulse", bus.rvalid0, 0);
        chk("rd0 rdata0 hold", bus.rdata0, 32'hEA);

        // Write from requester 1 to seed a second location
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 16'h0123; bus.wdata1 = 8'h5C;
        tick();
        chk("wr1 ack1", bus.ack1, 1);
        chk("wr1 ack0", bus.ack0, 0);
        chk("wr1 ramAddr", bus.ramAddr, 32'h0123);
        chk("wr1 ramDataOut", bus.ramDataOut, 32'h5C);
        bus.req1 = 0;
        tick();

        // Reset, then simultaneous reads: requester 0 first
        rstN = 1'b0;
        #1;
        chk_all_zero("reset2");
        tick();
        rstN = 1'b1;
        tick();
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0FAA;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 16'h0123;
        tick();
        chk("tie ack0", bus.ack0, 1);
        chk("tie ack1 first", bus.ack1, 0);
        chk("tie addr0", bus.ramAddr, 32'h0FAA);
        bus.req0 = 0;
        tick();
        chk("tie ack1 +1", bus.ack1, 0);
        tick();
        chk("tie ack1 +2", bus.ack1, 0);
        chk("tie rvalid0", bus.rvalid0, 1);
        chk("tie rdata0", bus.rdata0, 32'hEA);
        tick();
        chk("tie ack1 +3", bus.ack1, 1);
        chk("tie addr1", bus.ramAddr, 32'h0123);
        bus.req1 = 0;
        tick();
        tick();
        chk("tie rvalid1", bus.rvalid1, 1);
        chk("tie rdata1", bus.rdata1, 32'h5C);
        tick();

        // Both requesters hold writes: grants alternate starting with 0
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 16'h0200; bus.wdata0 = 8'h11;
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 16'h0300; bus.wdata1 = 8'h22;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("rr%0d ack0", i), bus.ack0, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("rr%0d ack1", i), bus.ack1, (i % 2 == 1) ? 1 : 0);
            chk($sformatf("rr%0d we&re", i), bus.ramWe & bus.ramRe, 0);
            if (i == 7) begin
                bus.req0 = 0;
                bus.req1 = 0;
            end
            tick();
            chk($sformatf("rr%0d idle busy", i), bus.busy, 0);
            chk($sformatf("rr%0d idle we&re", i), bus.ramWe & bus.ramRe, 0);
        end
        tick();
        chk("rr quiet ack0", bus.ack0, 0);

        // Reset during CAPTURE of a requester 1 read
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 16'h0123;
        tick();
        chk("abort ack1", bus.ack1, 1);
        bus.req1 = 0;
        tick();
        chk("abort capture busy", bus.busy, 1);
        rstN = 1'b0;
        #1;
        chk_all_zero("abort");
        tick();
        tick();
        rstN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("abort post%0d rvalid1", i), bus.rvalid1, 0);
            chk($sformatf("abort post%0d busy", i), bus.busy, 0);
        end

        // Next tie goes to requester 0
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 16'h0FAA;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 16'h0123;
        tick();
        chk("post ack0", bus.ack0, 1);
        chk("post ack1", bus.ack1, 0);
        bus.req0 = 0;
        tick();
        tick();
        chk("post rdata0", bus.rdata0, 32'hEA);
        tick();
        chk("post ack1 later", bus.ack1, 1);
        bus.req1 = 0;
        tick();
        tick();
        chk("post rvalid1", bus.rvalid1, 1);
        chk("post rdata1", bus.rdata1, 32'h5C);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, address width of every requester port and the RAM address output.
REQ-002 Parameter DATA_W, default 8, data width of every requester port and the RAM data buses.
REQ-003 clk  input  1  single clock; every flop is rising-edge triggered.
REQ-004 rstN  input  1  reset, asynchronous, active-low.
REQ-005 req0 / req1  input  1  request from requester 0 / 1; held high until the matching ack.
REQ-006 we0 / we1  input  1  1 = write, 0 = read; stable while req is high.
REQ-007 addr0 / addr1  input  ADDR_W  request address; stable while req is high.
REQ-008 wdata0 / wdata1  input  DATA_W  write data; stable while req is high.
REQ-009 ack0 / ack1  output  1  one-cycle pulse when that requester's command is issued to the RAM.
REQ-010 rvalid0 / rvalid1  output  1  one-cycle pulse when rdata0 / rdata1 holds returned read data.
REQ-011 rdata0 / rdata1  output  DATA_W  read data; holds its last value until the next capture for that requester.
REQ-012 ramCs  output  1  RAM chip select.
REQ-013 ramWe  output  1  RAM write enable.
REQ-014 ramRe  output  1  RAM read enable.
REQ-015 ramAddr  output  ADDR_W  RAM address.
REQ-016 ramDataOut  output  DATA_W  data driven onto the RAM write bus.
REQ-017 ramDataIn  input  DATA_W  RAM read bus; valid one clock after the read-issue edge.
REQ-018 busy  output  1  high whenever the state is not IDLE.

Function
REQ-019 All outputs shall be registered.
REQ-020 FSM states: IDLE, ISSUE, CAPTURE.
REQ-021 In IDLE with no request pending, the FSM shall stay in IDLE; ramCs, ramWe and ramRe shall be 0.
REQ-022 In IDLE with any request pending, one requester shall be granted and the FSM shall move to ISSUE on the next edge.
REQ-023 At the grant edge, the granted requester's we, addr and wdata shall be latched internally.
REQ-024 Arbitration: only one requesting -> grant it; both requesting -> grant the one opposite to lastGrant (round-robin).
REQ-025 lastGrant shall update to the granted index at the grant edge.
REQ-026 ISSUE lasts exactly 1 cycle.
REQ-027 During ISSUE: ramCs=1, ramAddr = latched addr, ramWe = latched we, ramRe = !latched we, ramDataOut = latched wdata (ramDataOut = 0 for reads).
REQ-028 During ISSUE, ack of the granted requester shall be 1; all other acks shall be 0.
REQ-029 ISSUE -> IDLE if the command is a write; ISSUE -> CAPTURE if it is a read.
REQ-030 CAPTURE lasts exactly 1 cycle; ramCs, ramWe and ramRe shall be 0.
REQ-031 At the edge leaving CAPTURE, ramDataIn shall be latched into rdata of the granted requester, and that requester's rvalid shall pulse for the following cycle.
REQ-032 The FSM shall return to IDLE after CAPTURE.
REQ-033 Timing: write = 2 cycles from grant to IDLE; read = 3 cycles.
REQ-034 Timing: rvalid asserts 2 cycles after the ack cycle begins.
REQ-035 A req that drops after grant shall not affect the command in flight.
REQ-036 A req still high in the ack cycle shall be treated as a new request at the next IDLE.
REQ-037 Starvation: with both requests held high continuously, grants shall alternate 0,1,0,1...
REQ-038 At most one RAM command shall be outstanding; requests arriving while busy shall wait.

Reset
REQ-039 rstN low shall immediately force the following, regardless of state or in-flight command: state=IDLE, lastGrant=1 (requester 0 wins the first tie), all ack/rvalid/ramCs/ramWe/ramRe=0, ramAddr/ramDataOut/rdata0/rdata1=0, busy=0.
REQ-040 A read interrupted by reset shall produce no rvalid after reset release.

Verification
REQ-041 Reset release; req0=1, we0=1, addr0=16'h0FAA, wdata0=8'hEA -> ack0 for 1 cycle with ramCs=1, ramWe=1, ramAddr=16'h0FAA, ramDataOut=8'hEA; busy low 2 cycles after grant.
REQ-042 Following the write, req0 read of 16'h0FAA; RAM model returns 8'hEA -> ack0, then rvalid0 pulse 2 cycles later with rdata0=8'hEA; rdata1 unchanged (0).
REQ-043 req0 and req1 rise on the same edge after reset, both reads -> requester 0 served first, then requester 1; ack1 appears exactly 3 cycles after ack0.
REQ-044 req0 and req1 held high, all writes, for 8 commands -> ack sequence 0,1,0,1,0,1,0,1; no cycle with ramWe and ramRe both 1.
REQ-045 rstN pulsed low during CAPTURE of a requester 1 read -> all outputs 0 immediately; no rvalid1 after release; the next tie is granted to requester 0.
